pcs_8b10b_enc: RTL



---
 rtl/pcs_8b10b_enc_if.sv | 19 +
 rtl/pcs_8b10b_enc.sv | 125 ++++++++++++
 2 files changed

// File: rtl/pcs_8b10b_enc_if.sv
// Code-group bus between the ordered-set transmit state machine (master) and
// the 8b/10b encoder (slave).
interface pcs_8b10b_enc_if;
  logic [7:0] tx_code_group;
  logic       control;
  logic [9:0] tx_10b;
  logic       tx_disparity;
  logic       kerr;

  modport master (
    output tx_code_group, control,
    input  tx_10b, tx_disparity, kerr
  );

  modport slave (
    input  tx_code_group, control,
    output tx_10b, tx_disparity, kerr
  );
endinterface

// File: rtl/pcs_8b10b_enc.sv
// 1000BASE-X 8b/10b encoder with running-disparity tracking, one group per clock.
// Optional macro PCS_ENC_KCHECK_EN: invalid K groups are sent as /V/ (K30.7) and flagged on kerr.
module pcs_8b10b_enc (
  input  logic           clk,
  input  logic           reset,
  pcs_8b10b_enc_if.slave enc
);

  logic [4:0] x_e;
  logic [2:0] y_e;
  logic       k_e;
  logic       kerr_d;
  logic [5:0] six_m, six;
  logic [3:0] four_m, four;
  logic       alt7, inv4, rd_mid, rd_d;
  logic [9:0] code_d;

  logic [9:0] tx_10b_q;
  logic       rd_q;
  logic       kerr_q;

  always_comb begin
    x_e    = enc.tx_code_group[4:0];
    y_e    = enc.tx_code_group[7:5];
    k_e    = enc.control;
    kerr_d = 1'b0;
`ifdef PCS_ENC_KCHECK_EN
    if (enc.control &&
        !((x_e == 5'd28) ||
          ((y_e == 3'd7) && (x_e == 5'd23 || x_e == 5'd27 || x_e == 5'd29 || x_e == 5'd30)))) begin
      x_e    = 5'd30;
      y_e    = 3'd7;
      kerr_d = 1'b1;
    end
`endif

    // 5b/6b RD- forms; the RD+ form is the complement for unbalanced codes and D.7
    six_m = 6'b000000;
    case (x_e)
      5'd0:  six_m = 6'b100111;
      5'd1:  six_m = 6'b011101;
      5'd2:  six_m = 6'b101101;
      5'd3:  six_m = 6'b110001;
      5'd4:  six_m = 6'b110101;
      5'd5:  six_m = 6'b101001;
      5'd6:  six_m = 6'b011001;
      5'd7:  six_m = 6'b111000;
      5'd8:  six_m = 6'b111001;
      5'd9:  six_m = 6'b100101;
      5'd10: six_m = 6'b010101;
      5'd11: six_m = 6'b110100;
      5'd12: six_m = 6'b001101;
      5'd13: six_m = 6'b101100;
      5'd14: six_m = 6'b011100;
      5'd15: six_m = 6'b010111;
      5'd16: six_m = 6'b011011;
      5'd17: six_m = 6'b100011;
      5'd18: six_m = 6'b010011;
      5'd19: six_m = 6'b110010;
      5'd20: six_m = 6'b001011;
      5'd21: six_m = 6'b101010;
      5'd22: six_m = 6'b011010;
      5'd23: six_m = 6'b111010;
      5'd24: six_m = 6'b110011;
      5'd25: six_m = 6'b100110;
      5'd26: six_m = 6'b010110;
      5'd27: six_m = 6'b110110;
      5'd28: six_m = k_e ? 6'b001111 : 6'b001110;
      5'd29: six_m = 6'b101110;
      5'd30: six_m = 6'b011110;
      5'd31: six_m = 6'b101011;
      default: six_m = 6'b000000;
    endcase
    six = (rd_q && (($countones(six_m) != 3) || (six_m == 6'b111000))) ? ~six_m : six_m;

    if (($countones(six) > 3) || (six == 6'b000111))      rd_mid = 1'b1;
    else if (($countones(six) < 3) || (six == 6'b111000)) rd_mid = 1'b0;
    else                                                  rd_mid = rd_q;

    // A7 keeps run length bounded where P7 would create five equal bits
    alt7 = k_e ||
           (!rd_mid && (x_e == 5'd17 || x_e == 5'd18 || x_e == 5'd20)) ||
           ( rd_mid && (x_e == 5'd11 || x_e == 5'd13 || x_e == 5'd14));

    four_m = 4'b0000;
    case (y_e)
      3'd0: four_m = 4'b1011;
      3'd1: four_m = 4'b1001;
      3'd2: four_m = 4'b0101;
      3'd3: four_m = 4'b1100;
      3'd4: four_m = 4'b1101;
      3'd5: four_m = 4'b1010;
      3'd6: four_m = 4'b0110;
      3'd7: four_m = alt7 ? 4'b0111 : 4'b1110;
      default: four_m = 4'b0000;
    endcase
    // K column flips the neutral codes when entering at RD-
    if (rd_mid) inv4 = (y_e == 3'd0) || (y_e == 3'd3) || (y_e == 3'd4) || (y_e == 3'd7);
    else        inv4 = k_e && ((y_e == 3'd1) || (y_e == 3'd2) || (y_e == 3'd5) || (y_e == 3'd6));
    four = inv4 ? ~four_m : four_m;

    if (($countones(four) > 2) || (four == 4'b0011))      rd_d = 1'b1;
    else if (($countones(four) < 2) || (four == 4'b1100)) rd_d = 1'b0;
    else                                                  rd_d = rd_mid;

    code_d = {six, four};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_10b_q <= 10'b0000000000;
      rd_q     <= 1'b0;
      kerr_q   <= 1'b0;
    end else begin
      tx_10b_q <= code_d;
      rd_q     <= rd_d;
      kerr_q   <= kerr_d;
    end
  end

  assign enc.tx_10b       = tx_10b_q;
  assign enc.tx_disparity = rd_q;
  assign enc.kerr         = kerr_q;

endmodule
